pwm_log_gen: RTL and testbench

PWM_LOG_GEN -- requirements
Module: pwm_log_gen

---
 rtl/pwm_log_gen.sv | 110 +++++++++++
 tb/tb_pwm_log_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_log_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_log_gen
// Description : Prescaled PWM generator with wrap-synchronous duty update.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_log_gen #(
    parameter int PERIOD    = 10000,
    parameter int PRESC_DIV = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [13:0] duty_in,
    input  logic        duty_load,
    output logic        pwm_out,
    output logic        period_end,
    output logic        update_pending,
    output logic [13:0] duty_active
);

    localparam int            c_pw         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(PRESC_DIV - 1);
    localparam logic [13:0]   c_cnt_last   = 14'(PERIOD - 1);
    localparam logic [13:0]   c_duty_max   = 14'(PERIOD);

    logic [c_pw-1:0] presc_q, presc_d;
    logic [13:0]     cnt_q, cnt_d;
    logic [13:0]     duty_pend_q, duty_pend_d;
    logic [13:0]     duty_active_q, duty_active_d;
    logic            pending_q, pending_d;
    logic            pwm_q, pwm_d;
    logic            period_end_q, period_end_d;
    logic            enable_q;

    logic            w_tick;
    logic            w_wrap;
    logic            w_en_rise;
    logic            w_apply;
    logic [13:0]     w_duty_clamped;

    always_comb begin
        w_tick         = enable && (presc_q == c_presc_last);
        w_wrap         = w_tick && (cnt_q == c_cnt_last);
        w_en_rise      = enable && !enable_q;
        // A restart is treated like a wrap: it is the next safe point to swap duty.
        w_apply        = w_wrap || w_en_rise;
        w_duty_clamped = (duty_in > c_duty_max) ? c_duty_max : duty_in;

        presc_d = '0;
        if (enable && (presc_q != c_presc_last)) begin
            presc_d = presc_q + 1'b1;
        end

        cnt_d = cnt_q;
        if (!enable || w_wrap) begin
            cnt_d = '0;
        end else if (w_tick) begin
            cnt_d = cnt_q + 14'd1;
        end

        duty_pend_d   = duty_pend_q;
        duty_active_d = duty_active_q;
        pending_d     = pending_q;
        if (duty_load) begin
            duty_pend_d = w_duty_clamped;
            if (w_apply) begin
                duty_active_d = w_duty_clamped;
                pending_d     = 1'b0;
            end else begin
                pending_d     = 1'b1;
            end
        end else if (w_apply && pending_q) begin
            duty_active_d = duty_pend_q;
            pending_d     = 1'b0;
        end

        pwm_d        = enable && (cnt_q < duty_active_q);
        period_end_d = w_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            cnt_q         <= '0;
            duty_pend_q   <= '0;
            duty_active_q <= '0;
            pending_q     <= 1'b0;
            pwm_q         <= 1'b0;
            period_end_q  <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            duty_pend_q   <= duty_pend_d;
            duty_active_q <= duty_active_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            period_end_q  <= period_end_d;
            enable_q      <= enable;
        end
    end

    assign pwm_out        = pwm_q;
    assign period_end     = period_end_q;
    assign update_pending = pending_q;
    assign duty_active    = duty_active_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_log_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_log_gen
// Description : Scoreboard bench for two pwm_log_gen instances sharing stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_log_gen;

    localparam int PER0 = 200;
    localparam int PRE0 = 3;
    localparam int PER1 = 2;
    localparam int PRE1 = 1;

    typedef struct packed {
        logic        pwm;
        logic        pe;
        logic        up;
        logic [13:0] da;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        duty_load = 1'b0;
    logic [13:0] duty_in = '0;

    logic        pwm0, pe0, up0, pwm1, pe1, up1;
    logic [13:0] da0, da1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference state: enabled-cycle count since (re)start plus duty registers.
    int ec[2];
    int act[2];
    int pend[2];
    bit pending[2];
    bit enp[2];
    int per[2];
    int pre[2];
    bit cur_en = 1'b0;

    always #5 clk = ~clk;

    pwm_log_gen #(.PERIOD(PER0), .PRESC_DIV(PRE0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .duty_in(duty_in), .duty_load(duty_load),
        .pwm_out(pwm0), .period_end(pe0), .update_pending(up0), .duty_active(da0)
    );

    pwm_log_gen #(.PERIOD(PER1), .PRESC_DIV(PRE1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .duty_in(duty_in), .duty_load(duty_load),
        .pwm_out(pwm1), .period_end(pe1), .update_pending(up1), .duty_active(da1)
    );

    function automatic bit wrap_next(int k, bit en);
        return en && (((ec[k] + 1) % (pre[k] * per[k])) == 0);
    endfunction

    task automatic model_step(input int k, input bit r, input bit en, input bit ld,
                              input int din, output exp_t e);
        int  cnt;
        bit  wr;
        bit  apply;
        int  cl;
        e = '0;
        if (r) begin
            ec[k] = 0; act[k] = 0; pend[k] = 0; pending[k] = 1'b0; enp[k] = 1'b0;
        end else begin
            cnt   = (ec[k] / pre[k]) % per[k];
            wr    = wrap_next(k, en);
            e.pwm = en && (cnt < act[k]);
            e.pe  = wr;
            ec[k] = en ? ec[k] + 1 : 0;
            apply = wr || (en && !enp[k]);
            cl    = (din > per[k]) ? per[k] : din;
            if (ld) begin
                pend[k] = cl;
                if (apply) begin
                    act[k] = cl; pending[k] = 1'b0;
                end else begin
                    pending[k] = 1'b1;
                end
            end else if (apply && pending[k]) begin
                act[k] = pend[k]; pending[k] = 1'b0;
            end
            enp[k] = en;
            e.up = pending[k];
            e.da = 14'(act[k]);
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit ld, input int din);
        exp_t e;
        @(negedge clk);
        rst = r; enable = en; duty_load = ld; duty_in = 14'(din);
        model_step(0, r, en, ld, din, e); q0.push_back(e);
        model_step(1, r, en, ld, din, e); q1.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, cur_en, 1'b0, 0);
    endtask

    task automatic load(input int din);
        cyc(1'b0, cur_en, 1'b1, din);
    endtask

    task automatic compare(input int k, input exp_t exp_v, input exp_t got);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL dut%0d outputs @%0t: got pwm=%b pe=%b up=%b da=%0d, expected pwm=%b pe=%b up=%b da=%0d",
                     k, $time, got.pwm, got.pe, got.up, got.da,
                     exp_v.pwm, exp_v.pe, exp_v.up, exp_v.da);
        end
    endtask

    // Monitor: the DUT presents a fresh output every clock; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare(0, e, {pwm0, pe0, up0, da0});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare(1, e, {pwm1, pe1, up1, da1});
            end
        end
    end

    initial begin
        int guard;
        int sel;
        int din;
        per[0] = PER0; pre[0] = PRE0; per[1] = PER1; pre[1] = PRE1;
        for (int k = 0; k < 2; k++) begin
            ec[k] = 0; act[k] = 0; pend[k] = 0; pending[k] = 1'b0; enp[k] = 1'b0;
        end

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 0);
        cur_en = 1'b1;
        run(1);
        load(50);          run(1300);
        load(0);           run(700);
        load(PER0);        run(700);
        load(16000);       run(700);
        run(150);
        load(120); run(5); load(30); run(700);

        // Load exactly in the wrap cycle of the first instance.
        guard = 0;
        while (!wrap_next(0, 1'b1) && guard < 2000) begin
            run(1); guard++;
        end
        load(70); run(700);

        // Disable mid-period with a load while idle, then restart.
        run(100);
        cur_en = 1'b0; run(10); load(150); run(10);
        cur_en = 1'b1; run(1300);

        // Reset mid-period: output must stay low afterwards until reloaded.
        load(160); run(900);
        cyc(1'b1, 1'b1, 1'b1, 90);
        run(1300);
        load(40); run(1300);

        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 299) == 0) cur_en = !cur_en;
            if ($urandom_range(0, 2999) == 0) begin
                cyc(1'b1, cur_en, 1'b0, 0);
            end else if ($urandom_range(0, 39) == 0) begin
                sel = $urandom_range(0, 4);
                case (sel)
                    0:       din = 0;
                    1:       din = PER0;
                    2:       din = PER0 + $urandom_range(1, 16383 - PER0);
                    3:       din = $urandom_range(0, 16383);
                    default: din = $urandom_range(0, PER0);
                endcase
                load(din);
            end else begin
                run(1);
            end
        end

        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
